dma_read_engine: RTL
====================

# dma_read_engine

AXI4 read master that fetches a contiguous byte region from DDR and pushes it, one 32-bit word per beat, into a downstream FIFO. It is the read-side counterpart of `dma_master_engine`. It uses the same control handshake (start, base address, length, done) and the same 4 KB page-split rule. It sits between the DDR interconnect and the accelerator input FIFO.

## Interface
Parameters:
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, AXI/FIFO data width; 4 bytes per beat, fixed
- `MAX_BURST`, 16, maximum beats per burst (`arlen` ≤ MAX_BURST-1)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  one-cycle start pulse; ignored unless the engine is IDLE
- `i_base_addr`  in  32  byte address; bits [1:0] must be 0
- `i_total_len`  in  32  byte count; multiple of 4; 0 is legal
- `o_done`  out  1  one-cycle completion pulse
- `o_busy`  out  1  high from the cycle after start until `o_done`
- `o_err`  out  1  sticky error flag; cleared on the next accepted start
- `m_axi_araddr`  out  32  burst start address
- `m_axi_arlen`  out  8  beats-1
- `m_axi_arsize`  out  3  constant 3'b010
- `m_axi_arburst`  out  2  constant INCR (2'b01)
- `m_axi_arvalid`  out  1  address valid
- `m_axi_arready`  in  1  address ready
- `m_axi_rdata`  in  32  read data
- `m_axi_rresp`  in  2  read response
- `m_axi_rlast`  in  1  last beat of burst
- `m_axi_rvalid`  in  1  data valid
- `m_axi_rready`  out  1  data ready
- `i_fifo_full`  in  1  FIFO cannot accept a write this cycle
- `o_fifo_wen`  out  1  FIFO write strobe
- `o_fifo_wdata`  out  32  FIFO write data

## Operation
- States: IDLE, CALC, ADDR, DATA, DONE.
- **IDLE**
  - On `i_start`: latch `cur_addr` = base and `rem_beats` = len>>2, and clear `o_err`.
  - If `rem_beats` = 0, go to DONE; otherwise go to CALC.
- **CALC**
  - `page_beats` = (4096 - cur_addr[11:0]) >> 2, computed 13 bits wide.
  - `burst` = min(`rem_beats`, `MAX_BURST`, `page_beats`).
  - Register `arlen` = burst-1 and `araddr` = cur_addr, then go to ADDR.
- **ADDR**
  - `arvalid` = 1. `araddr` and `arlen` are held stable until `arready`.
  - On handshake: `cur_addr` += burst*4, `rem_beats` -= burst, load `beat_cnt` = burst-1, go to DATA.
- **DATA**
  - `rready` = !`i_fifo_full`.
  - Each beat with `rvalid` && `rready`: `o_fifo_wen` = 1, `o_fifo_wdata` = `rdata` (combinational pass-through), `beat_cnt` decrements.
  - `rresp` ≠ OKAY sets `o_err`. The burst is still drained and the data is still written.
  - `rlast` asserted while `beat_cnt` ≠ 0, or `beat_cnt` = 0 without `rlast`, sets `o_err`. The burst terminates on `rlast`.
  - After the last beat: go to CALC if `rem_beats` ≠ 0, else DONE.
- **DONE**: `o_done` = 1 for one cycle, then go to IDLE.
- Only one burst is outstanding at a time. `rready` is 0 outside DATA.
- Address arithmetic wraps at 2^32 with no special handling. Crossing a 4 KB page is never permitted within one burst.

## Timing
- Reset values:
  - all outputs 0 except `m_axi_arsize` = 3'b010 and `m_axi_arburst` = 2'b01
  - state IDLE
  - `o_err` = 0
- Asserting `rst_n` low mid-transfer returns to IDLE immediately and drops `arvalid`/`rready`/`o_fifo_wen` asynchronously. No partial completion is reported.
- Start latency: `i_start` sampled at edge N, CALC in N+1, `arvalid` high from N+2.
- Zero-length request: `o_done` is high in cycle N+1 and no AR is issued.
- Inter-burst gap: the last R beat is at edge M, CALC in M+1, next `arvalid` at M+2.
- Completion: the last R beat is at edge M, so `o_done` is high in cycle M+1.
- `rvalid` high while `i_fifo_full`: `rready` = 0, no write, data held by the slave.
- `i_start` outside IDLE has no effect.

## Structure
- Shared package `dma_pkg` holds:
  - state enum `dma_rd_state_t`
  - `AXI_BURST_INCR`, `AXI_RESP_OKAY`, `BYTES_PER_BEAT` = 4, `PAGE_BYTES` = 4096
- Sub-module `dma_burst_splitter` is combinational: (addr, rem_beats, MAX_BURST) → burst beats. It is reusable by the write engine.

## Test plan
- Base 0x0FF0, len 64, always-ready slave:
  - AR 1 is (0x0FF0, len 3); AR 2 is (0x1000, len 11).
  - 16 FIFO writes in order, then `o_done`, `o_err` = 0.
- Base 0x0000, len 128: AR 1 is (0x0000, len 15), AR 2 is (0x0040, len 15), 32 writes, `o_done`.
- Len 0: `o_done` is high 1 cycle after start, `arvalid` never asserts.
- Base 0x2000, len 16, with `i_fifo_full` held high for beats 2–3 for 5 cycles:
  - `rready` = 0 and no `o_fifo_wen` while full.
  - All 4 words are written in order afterwards.
- Base 0x0, len 16, `rresp` = SLVERR on beat 2: all 4 beats written, `o_done` high with `o_err` = 1.
- Reset pulsed during the DATA phase of burst 1: all outputs return to reset values.
  - A new start (0x0FF0, 64) then completes correctly.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA engines
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } dma_rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam int         BYTES_PER_BEAT = 4;
  localparam int         PAGE_BYTES     = 4096;

  // Beats left before the next 4 KB boundary; an aligned address yields a full page.
  function automatic logic [12:0] beats_to_page(input logic [11:0] page_off);
    return (13'(PAGE_BYTES) - {1'b0, page_off}) >> 2;
  endfunction

endpackage

// File: rtl/dma_read_engine_if.sv
// rtl/dma_read_engine_if.sv - AXI4 read address/data channel bundle
interface dma_read_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );
endinterface

// File: rtl/dma_burst_splitter.sv
// rtl/dma_burst_splitter.sv - picks the next burst size without crossing a 4 KB page
module dma_burst_splitter
  import dma_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [11:0] page_off_i,
  input  logic [31:0] rem_beats_i,
  output logic [12:0] burst_o
);

  logic [12:0] page_beats;
  logic [12:0] cap;

  // burst = min(remaining beats, MAX_BURST, beats to page end)
  always_comb begin
    page_beats = beats_to_page(page_off_i);
    cap        = 13'(MAX_BURST);
    if (page_beats < cap) cap = page_beats;
    if (rem_beats_i < 32'(cap)) burst_o = rem_beats_i[12:0];
    else                        burst_o = cap;
  end

endmodule

// File: rtl/dma_read_engine.sv
// rtl/dma_read_engine.sv - AXI4 read master streaming a byte region into a FIFO
module dma_read_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_base_addr,
  input  logic [31:0]         i_total_len,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_err,
  dma_read_engine_if.master   m_axi,
  input  logic                i_fifo_full,
  output logic                o_fifo_wen,
  output logic [DATA_W-1:0]   o_fifo_wdata
);

  dma_rd_state_t     state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [31:0]       rem_beats_q;
  logic [7:0]        arlen_q;
  logic [7:0]        beat_cnt_q;
  logic [12:0]       burst_q;
  logic [12:0]       burst_d;
  logic              arvalid_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;
  logic              rready;
  logic              beat_hs;
  logic              beat_bad;

  dma_burst_splitter #(
    .MAX_BURST (MAX_BURST)
  ) u_splitter (
    .page_off_i  (cur_addr_q[11:0]),
    .rem_beats_i (rem_beats_q),
    .burst_o     (burst_d)
  );

  // R-channel acceptance and per-beat protocol checks; rready follows FIFO space only in DATA
  always_comb begin
    rready   = (state_q == ST_DATA) && !i_fifo_full;
    beat_hs  = rready && m_axi.m_axi_rvalid;
    beat_bad = (m_axi.m_axi_rresp != AXI_RESP_OKAY) ||
               (m_axi.m_axi_rlast != (beat_cnt_q == 8'd0));
  end

  // Control FSM: one burst outstanding, address phase then data phase, repeat until drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      araddr_q    <= '0;
      rem_beats_q <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      burst_q     <= '0;
      arvalid_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            cur_addr_q  <= i_base_addr;
            rem_beats_q <= i_total_len >> 2;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            if ((i_total_len >> 2) == 32'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          araddr_q  <= cur_addr_q;
          arlen_q   <= 8'(burst_d - 13'd1);
          burst_q   <= burst_d;
          arvalid_q <= 1'b1;
          state_q   <= ST_ADDR;
        end
        ST_ADDR: begin
          if (m_axi.m_axi_arready) begin
            arvalid_q   <= 1'b0;
            cur_addr_q  <= cur_addr_q + ADDR_W'({burst_q, 2'b00});
            rem_beats_q <= rem_beats_q - 32'(burst_q);
            beat_cnt_q  <= 8'(burst_q - 13'd1);
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_hs) begin
            if (beat_bad) err_q <= 1'b1;
            if (beat_cnt_q != 8'd0) beat_cnt_q <= beat_cnt_q - 8'd1;
            // The slave's rlast ends the burst even when it disagrees with our count.
            if (m_axi.m_axi_rlast) begin
              if (rem_beats_q != 32'd0) begin
                state_q <= ST_CALC;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axi.m_axi_araddr  = araddr_q;
  assign m_axi.m_axi_arlen   = arlen_q;
  assign m_axi.m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi.m_axi_arburst = AXI_BURST_INCR;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready;
  assign o_fifo_wen          = beat_hs;
  assign o_fifo_wdata        = m_axi.m_axi_rdata;
  assign o_done              = done_q;
  assign o_busy              = busy_q;
  assign o_err               = err_q;

endmodule
